// File: rtl/stack_pkg.sv
// Shared opcode constants and FSM state encoding for the stack sequencer.
// Optional arithmetic states are present only when STACK_SEQ_ARITH_EN is defined.
package stack_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
   localparam logic [OP_W-1:0] OP_POP  = 4'b0001;
   localparam logic [OP_W-1:0] OP_DROP = 4'b0010;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0011;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0100;
   localparam logic [OP_W-1:0] OP_DUP  = 4'b0101;
   localparam logic [OP_W-1:0] OP_SWAP = 4'b0111;
   localparam logic [OP_W-1:0] OP_PUSH = 4'b1000;

`ifdef STACK_SEQ_ARITH_EN
   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      A_LATCH,
      A_DROP1,
      A_DROP2,
      A_PUSH
   } state_t;
`else
   typedef enum logic [0:0] {
      IDLE,
      EXEC
   } state_t;
`endif

endpackage

// File: rtl/stack_sequencer_if.sv
// Instruction channel plus downstream stack command/status channel.
// master = instruction source and downstream stack; slave = sequencer.
interface stack_sequencer_if #(
   parameter int unsigned WIDTH = 16
);
   logic             instr_valid;
   logic             instr_ready;
   logic [3:0]       instr_op;
   logic [WIDTH-1:0] instr_imm;
   logic [3:0]       stack_action;
   logic [WIDTH-1:0] stack_val;
   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] next;
   logic             pop_valid;
   logic [WIDTH-1:0] pop_data;

   modport master (
      output instr_valid, instr_op, instr_imm, top, next,
      input  instr_ready, stack_action, stack_val, pop_valid, pop_data
   );

   modport slave (
      input  instr_valid, instr_op, instr_imm, top, next,
      output instr_ready, stack_action, stack_val, pop_valid, pop_data
   );
endinterface

// File: rtl/stack_sequencer.sv
// Stack sequencer: turns instructions into registered commands for an external stack.
// Define STACK_SEQ_ARITH_EN to enable add/sub; otherwise those opcodes are illegal.
module stack_sequencer
   import stack_pkg::*;
#(
   parameter  int unsigned WIDTH   = 16,
   parameter  int unsigned DEPTH   = 10,
   localparam int unsigned DEPTH_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   stack_sequencer_if.slave   bus,
   output logic [DEPTH_W-1:0] depth,
   output logic               err_overflow,
   output logic               err_underflow,
   output logic               err_illegal
);

   state_t state;
   logic   accept_c;
   logic   is_nop_c;
   logic   illegal_c;
   logic   ovf_c;
   logic   unf_c;
   logic   is_arith_c;
   logic   go_exec_c;
   logic   full_c;
   logic   lt2_c;

`ifdef STACK_SEQ_ARITH_EN
   logic [WIDTH-1:0] result;
   logic             sub_q;
`endif

   assign bus.instr_ready = (state == IDLE) && !rst;
   assign accept_c        = bus.instr_valid && bus.instr_ready;
   assign full_c          = (depth == DEPTH_W'(DEPTH));
   assign lt2_c           = (depth == DEPTH_W'(0)) || (depth == DEPTH_W'(1));

   // Classify the offered opcode against the current occupancy.
   always_comb begin
      is_nop_c   = 1'b0;
      illegal_c  = 1'b0;
      ovf_c      = 1'b0;
      unf_c      = 1'b0;
      is_arith_c = 1'b0;
      case (bus.instr_op)
         OP_NOP:          is_nop_c = 1'b1;
         OP_PUSH:         ovf_c    = full_c;
         OP_POP, OP_DROP: unf_c    = (depth == DEPTH_W'(0));
         OP_DUP: begin
            unf_c = (depth == DEPTH_W'(0));
            ovf_c = full_c;
         end
         OP_SWAP:         unf_c    = lt2_c;
`ifdef STACK_SEQ_ARITH_EN
         OP_ADD, OP_SUB: begin
            is_arith_c = 1'b1;
            unf_c      = lt2_c;
         end
`endif
         default:         illegal_c = 1'b1;
      endcase
   end

   assign go_exec_c = !is_nop_c && !illegal_c && !ovf_c && !unf_c && !is_arith_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         depth            <= '0;
         bus.stack_action <= OP_NOP;
         bus.stack_val    <= '0;
         bus.pop_valid    <= 1'b0;
         bus.pop_data     <= '0;
         err_overflow     <= 1'b0;
         err_underflow    <= 1'b0;
         err_illegal      <= 1'b0;
`ifdef STACK_SEQ_ARITH_EN
         result           <= '0;
         sub_q            <= 1'b0;
`endif
      end else begin
         bus.stack_action <= OP_NOP;
         bus.stack_val    <= '0;
         bus.pop_valid    <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  if (ovf_c)     err_overflow  <= 1'b1;
                  if (unf_c)     err_underflow <= 1'b1;
                  if (illegal_c) err_illegal   <= 1'b1;
                  if (go_exec_c) begin
                     state            <= EXEC;
                     bus.stack_action <= bus.instr_op;
                     bus.stack_val    <= (bus.instr_op == OP_PUSH) ? bus.instr_imm : '0;
                  end
`ifdef STACK_SEQ_ARITH_EN
                  if (is_arith_c && !unf_c) begin
                     state <= A_LATCH;
                     sub_q <= (bus.instr_op == OP_SUB);
                  end
`endif
               end
            end
            // Occupancy follows the command that was on the bus this cycle.
            EXEC: begin
               state <= IDLE;
               case (bus.stack_action)
                  OP_PUSH, OP_DUP: depth <= depth + DEPTH_W'(1);
                  OP_DROP:         depth <= depth - DEPTH_W'(1);
                  OP_POP: begin
                     depth         <= depth - DEPTH_W'(1);
                     bus.pop_valid <= 1'b1;
                     bus.pop_data  <= bus.top;
                  end
                  default: ;
               endcase
            end
`ifdef STACK_SEQ_ARITH_EN
            A_LATCH: begin
               result           <= sub_q ? (bus.next - bus.top) : (bus.next + bus.top);
               state            <= A_DROP1;
               bus.stack_action <= OP_DROP;
            end
            A_DROP1: begin
               depth            <= depth - DEPTH_W'(1);
               state            <= A_DROP2;
               bus.stack_action <= OP_DROP;
            end
            A_DROP2: begin
               depth            <= depth - DEPTH_W'(1);
               state            <= A_PUSH;
               bus.stack_action <= OP_PUSH;
               bus.stack_val    <= result;
            end
            A_PUSH: begin
               depth <= depth + DEPTH_W'(1);
               state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of stack entries.
REQ-002 SHALL have parameter DEPTH, default 10, stack capacity in entries.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port instr_valid  input  1  instruction offered.
REQ-006 SHALL have port instr_ready  output  1  sequencer accepts instruction this cycle.
REQ-007 SHALL have port instr_op  input  4  opcode: 1000 push, 0001 pop, 0010 drop, 0011 add, 0100 sub, 0101 dup, 0111 swap, 0000 nop.
REQ-008 SHALL have port instr_imm  input  WIDTH  push operand.
REQ-009 SHALL have port stack_action  output  4  registered command to downstream stack; 0000 = idle.
REQ-010 SHALL have port stack_val  output  WIDTH  value for push command.
REQ-011 SHALL have ports top, next  input  WIDTH each  current stack entries 0 and 1.
REQ-012 SHALL have ports pop_valid (1) and pop_data (WIDTH), outputs  popped value.
REQ-013 SHALL have ports depth  output  ceil(log2(DEPTH+1))  occupancy, and err_overflow, err_underflow, err_illegal  output  1 each  sticky flags.

Function
REQ-014 States SHALL be IDLE, EXEC, A_LATCH, A_DROP1, A_DROP2, A_PUSH.
REQ-015 instr_ready SHALL be 1 only in IDLE; a transfer occurs when instr_valid && instr_ready.
REQ-016 Accepted push/pop/drop/dup/swap SHALL go to EXEC for exactly one cycle with stack_action = opcode (stack_val = instr_imm for push, else 0), then return to IDLE.
REQ-017 Outside EXEC/A_DROP1/A_DROP2/A_PUSH, stack_action SHALL be 0000.
REQ-018 Pop SHALL sample top during EXEC; pop_valid SHALL pulse one cycle in the following cycle with that value on pop_data.
REQ-019 Add/sub SHALL run A_LATCH (latch next+top or next-top, modulo 2^WIDTH, action 0000), A_DROP1 (0010), A_DROP2 (0010), A_PUSH (1000, stack_val = latched result), then IDLE: 4 cycles.
REQ-020 depth SHALL change at end of command cycle: push/dup +1, pop/drop -1, add/sub net -1, swap/nop 0.
REQ-021 Push/dup at depth == DEPTH SHALL issue no action, set err_overflow, consume instruction, and keep depth unchanged.
REQ-022 Pop/drop/dup at depth 0, or swap/add/sub at depth < 2, SHALL issue no action, set err_underflow, and consume instruction.
REQ-023 Nop SHALL be consumed in one cycle with no action; opcodes not listed SHALL set err_illegal and be consumed with no action.
REQ-024 A rejected instruction SHALL return to IDLE the cycle after acceptance (no EXEC).
REQ-025 Error flags SHALL remain set until rst.

Reset
REQ-026 rst SHALL, at the next clk edge, force IDLE, depth 0, stack_action 0000, stack_val 0, pop_valid 0, pop_data 0, all error flags 0, latched result 0.
REQ-027 rst during an add/sub sequence SHALL abort it; no further actions issued.
REQ-028 instr_ready SHALL be 0 in the cycle rst is high.

Configuration
REQ-029 Macro STACK_SEQ_ARITH_EN defined: add/sub supported per REQ-019.
REQ-030 Macro undefined: A_* states absent; opcodes 0011/0100 SHALL be treated as illegal (REQ-023).

Structure
REQ-031 Opcode constants and state enumeration SHALL reside in shared package stack_pkg.
REQ-032 No sub-module; FSM, depth counter and result register SHALL be inline.

Verification
REQ-033 Reset, push 0x0005, push 0x0003 -> stack_action 1000 with stack_val 5 then 3 on consecutive EXEC cycles; depth 2.
REQ-034 Then add -> actions 0000,0010,0010,1000 with stack_val 0x0008; depth 1; instr_ready low for 4 cycles.
REQ-035 top=0x0003, next=0x0001, sub -> pushed value 0xFFFE (wrap).
REQ-036 10 pushes then 11th push -> no action, err_overflow=1, depth 10; pop -> pop_valid one cycle with prior top, depth 9.
REQ-037 From depth 1, swap -> err_underflow=1, stack_action stays 0000; opcode 1111 -> err_illegal=1.
REQ-038 rst asserted in A_DROP1 -> next cycle stack_action 0000, depth 0, IDLE.
